mode_switch_ctrl: RTL and testbench
===================================

// Module: mode_switch_ctrl
//
// PURPOSE
// Sequences MITM mode changes requested through the button/LED I/O handler.
// - Input: the requested mode, one-hot, from the I/O handler.
// - Output: active_mode, the mode used by the bus datapath handlers.
// - A change is applied only after the bus has been quiet for a set time and
//   the handlers confirm they are halted, so no frame is cut mid-transfer.
// - Sits between the I/O handler and the datapath handlers. comm_active also feeds the activity LED.
//
// PARAMETERS
// MODE_WIDTH      4        width of the one-hot mode vectors
// RESET_MODE      4'b0001  active_mode after reset; must be one-hot
// IDLE_CYCLES     16       consecutive comm_active=0 cycles needed before halting; >=1
// SETTLE_CYCLES   4        cycles halt_req stays high after the mode update; >=1
// TIMEOUT_CYCLES  1024     forced-switch limit; used only with MODE_SWITCH_TIMEOUT_EN
//
// PORTS
// sys_clk        in   1           system clock, single clock domain
// rst            in   1           asynchronous, active-high reset
// mode_req       in   MODE_WIDTH  requested mode, one-hot; any other value is invalid
// comm_active    in   1           a bus transaction is in progress
// halt_ack       in   1           handlers are stopped at a frame boundary
// halt_req       out  1           request to the handlers to stop at the next frame boundary
// active_mode    out  MODE_WIDTH  applied mode, one-hot, registered
// switch_pending out  1           high in every state except IDLE
// switch_done    out  1           1-cycle pulse when a switch completes
// switch_forced  out  1           1-cycle pulse on a timeout-forced switch
//
// BEHAVIOUR
// - All outputs are registered.
// - Reset (async): state=IDLE, active_mode=RESET_MODE, target=RESET_MODE,
//   all counters 0, all other outputs 0. Reset mid-switch abandons the switch.
// - IDLE:
//   - Valid mode_req different from active_mode: latch target, go to WAIT_QUIET.
//   - Invalid mode_req (zero or multi-hot) is ignored in every state.
// - WAIT_QUIET:
//   - quiet_cnt increments on each comm_active=0 cycle.
//   - Any comm_active=1 cycle clears quiet_cnt to 0.
//   - After IDLE_CYCLES consecutive quiet cycles, go to HALT and set halt_req=1.
//   - Valid mode_req to a new value: retarget; quiet_cnt is kept.
//   - Valid mode_req equal to active_mode: cancel to IDLE, no switch_done pulse.
// - HALT:
//   - halt_req=1; target is frozen. halt_ack is honoured only in this state.
//   - halt_ack=1: active_mode<=target on the next edge, go to SETTLE.
// - SETTLE:
//   - halt_req stays 1 for SETTLE_CYCLES cycles.
//   - In the following cycle: halt_req=0, switch_done=1 for one cycle, go to IDLE.
//   - A request pending on mode_req is evaluated again in IDLE.
// - Latency, measuring from the edge that samples a new mode_req, with comm_active=0
//   and halt_ack tied high:
//   - halt_req rises at IDLE_CYCLES+1.
//   - active_mode changes at IDLE_CYCLES+2.
//   - switch_done pulses and halt_req falls at IDLE_CYCLES+2+SETTLE_CYCLES.
// - active_mode is always one-hot and changes only on the HALT->SETTLE edge
//   (or a forced switch).
//
// CONFIGURATION
// MODE_SWITCH_TIMEOUT_EN defined:
// - wait_cnt counts every cycle spent in WAIT_QUIET and HALT; it clears on entering IDLE.
// - When wait_cnt reaches TIMEOUT_CYCLES, the switch is forced regardless of comm_active and halt_ack:
//   - active_mode<=target and switch_forced pulses in the same cycle.
//   - Then SETTLE runs normally and ends with switch_done.
// Not defined:
// - No wait_cnt; the controller waits indefinitely.
// - switch_forced is tied 0 and TIMEOUT_CYCLES is unused.
//
// TESTING (defaults, 12 MHz clock)
// - rst pulse mid-HALT -> active_mode=0001, halt_req=0, switch_pending=0, switch_done=0
//   within the same cycle (async).
// - mode_req=0010, comm_active=0, halt_ack=1 ->
//   - halt_req high for cycles 17..21.
//   - active_mode=0010 at cycle 18.
//   - switch_done single pulse at cycle 22.
// - As above plus a 1-cycle comm_active pulse at cycle 10 -> quiet_cnt restarts;
//   active_mode updates at cycle 28.
// - Request handling:
//   - mode_req 0010 then 0100 during WAIT_QUIET -> active_mode=0100 with exactly one switch_done.
//   - mode_req back to 0001 -> cancel, no pulse.
//   - mode_req 0000 or 0110 -> no state change.
// - halt_ack=0, comm_active=0 for 5000 cycles:
//   - Without macro: HALT held and active_mode unchanged.
//   - With macro: switch_forced pulses at wait_cnt=1024 and active_mode=target.

Source files
------------

// File: rtl/mode_switch_ctrl.sv
// mode_switch_ctrl: applies a requested one-hot mode once the bus is quiet and the handlers are halted.
// Optional: define MODE_SWITCH_TIMEOUT_EN to force the switch after TIMEOUT_CYCLES of waiting.
module mode_switch_ctrl #(
  parameter int                    MODE_WIDTH     = 4,
  parameter logic [MODE_WIDTH-1:0] RESET_MODE     = MODE_WIDTH'(1),
  parameter int                    IDLE_CYCLES    = 16,
  parameter int                    SETTLE_CYCLES  = 4,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [MODE_WIDTH-1:0] mode_req,
  input  logic                  comm_active,
  input  logic                  halt_ack,
  output logic                  halt_req,
  output logic [MODE_WIDTH-1:0] active_mode,
  output logic                  switch_pending,
  output logic                  switch_done,
  output logic                  switch_forced
);
  localparam int QW = $clog2(IDLE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_QUIET, HALT, SETTLE} state_t;
  state_t                state;
  logic [MODE_WIDTH-1:0] target;
  logic [QW-1:0]         quiet_cnt;
  logic [SW-1:0]         settle_cnt;
  logic                  req_valid, cancel, timeout, force_sw;
  if (RESET_MODE == '0 || (RESET_MODE & (RESET_MODE - 1'b1)) != '0 ||
      IDLE_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mode_switch_ctrl: invalid parameters");
  end
  assign req_valid = mode_req != '0 && (mode_req & (mode_req - 1'b1)) == '0;
  assign cancel    = req_valid && mode_req == active_mode;
  assign force_sw  = timeout && (state == HALT || (state == WAIT_QUIET && !cancel));
`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_cnt;
  // Count cycles spent waiting for a quiet bus or for halt_ack
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) wait_cnt <= '0;
    else wait_cnt <= (state == WAIT_QUIET || state == HALT) ? wait_cnt + 1'b1 : '0;
  assign timeout = wait_cnt == WW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout       = 1'b0;
  assign switch_forced = 1'b0;
`endif
  // Switch sequencer: wait for quiet bus, halt handlers, apply mode, settle
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      active_mode    <= RESET_MODE;
      target         <= RESET_MODE;
      quiet_cnt      <= '0;
      settle_cnt     <= '0;
      halt_req       <= 1'b0;
      switch_pending <= 1'b0;
      switch_done    <= 1'b0;
`ifdef MODE_SWITCH_TIMEOUT_EN
      switch_forced  <= 1'b0;
`endif
    end else begin
      switch_done <= 1'b0;
`ifdef MODE_SWITCH_TIMEOUT_EN
      switch_forced <= force_sw;
`endif
      if (force_sw) begin
        active_mode <= target;
        settle_cnt  <= '0;
        halt_req    <= 1'b1;
        state       <= SETTLE;
      end else
        case (state)
          IDLE:
            if (req_valid && !cancel) begin
              target         <= mode_req;
              quiet_cnt      <= '0;
              switch_pending <= 1'b1;
              state          <= WAIT_QUIET;
            end
          WAIT_QUIET:
            if (cancel) begin
              switch_pending <= 1'b0;
              state          <= IDLE;
            end else begin
              if (req_valid) target <= mode_req;
              if (quiet_cnt == QW'(IDLE_CYCLES)) begin
                halt_req <= 1'b1;
                state    <= HALT;
              end else quiet_cnt <= comm_active ? '0 : quiet_cnt + 1'b1;
            end
          HALT:
            if (halt_ack) begin
              active_mode <= target;
              settle_cnt  <= '0;
              state       <= SETTLE;
            end
          SETTLE:
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
              halt_req       <= 1'b0;
              switch_done    <= 1'b1;
              switch_pending <= 1'b0;
              state          <= IDLE;
            end else settle_cnt <= settle_cnt + 1'b1;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_mode_switch_ctrl.sv
// tb_mode_switch_ctrl: timeline model plus directed vectors for mode_switch_ctrl.
module tb_mode_switch_ctrl;
  localparam int IDLE = 16, SETTLE = 4, TMO = 1024;
`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic       sys_clk = 1'b0, rst = 1'b1, comm_active = 1'b0, halt_ack = 1'b1;
  logic [3:0] mode_req = 4'b0001, active_mode;
  logic       halt_req, switch_pending, switch_done, switch_forced;
  int         checks = 0, failures = 0, n = 0, e0 = 0, dones = 0, forced_seen = 0, d0;
  mode_switch_ctrl dut (
    .sys_clk(sys_clk), .rst(rst), .mode_req(mode_req), .comm_active(comm_active),
    .halt_ack(halt_ack), .halt_req(halt_req), .active_mode(active_mode),
    .switch_pending(switch_pending), .switch_done(switch_done), .switch_forced(switch_forced)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, n);
    end
  endtask
  // Model in terms of event timestamps: when the request was accepted, the last
  // busy-bus edge, when halt was raised and when the mode was applied.
  bit         busy = 0, m_done = 0, m_forced = 0;
  logic [3:0] m_act = 4'b0001, m_tgt = 4'b0001;
  int         acc, noise, halt_at, apply_at;
  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      busy = 0; m_act = 4'b0001; m_tgt = 4'b0001; m_done = 0; m_forced = 0;
    end else begin
      n++;
      m_done = 0;
      m_forced = 0;
      if (!busy) begin
        if ($onehot(mode_req) && mode_req != m_act) begin
          busy = 1; m_tgt = mode_req; acc = n; noise = n; halt_at = -1; apply_at = -1;
        end
      end else if (halt_at < 0) begin
        if ($onehot(mode_req) && mode_req == m_act) busy = 0;
        else if (TMO_EN && n - acc == TMO) begin
          m_act = m_tgt; m_forced = 1; halt_at = n; apply_at = n;
        end else begin
          if ((n - 1) - noise >= IDLE) halt_at = n;
          if ($onehot(mode_req)) m_tgt = mode_req;
          if (comm_active) noise = n;
        end
      end else if (apply_at < 0) begin
        if (TMO_EN && n - acc == TMO) begin
          m_act = m_tgt; m_forced = 1; apply_at = n;
        end else if (halt_ack) begin
          m_act = m_tgt; apply_at = n;
        end
      end else if (n == apply_at + SETTLE) begin
        busy = 0; m_done = 1;
      end
    end
  end
  always @(negedge sys_clk)
    if (!rst) begin
      check("active_mode", active_mode, m_act);
      check("halt_req", halt_req, busy && halt_at >= 0);
      check("switch_pending", switch_pending, busy);
      check("switch_done", switch_done, m_done);
      check("switch_forced", switch_forced, m_forced);
      if (switch_done) dones++;
      if (switch_forced) forced_seen++;
    end
  task automatic go(int k);
    while (n < e0 + k) @(negedge sys_clk);
  endtask
  task automatic cycles(int k);
    repeat (k) @(negedge sys_clk);
  endtask
  initial begin
    cycles(3);
    rst = 1'b0;
    check("reset_active", active_mode, 4'b0001);
    check("reset_halt", halt_req, 0);
    check("reset_pending", switch_pending, 0);
    check("reset_done", switch_done, 0);
    // Plain switch to 0010 with a quiet bus and halt_ack tied high
    mode_req = 4'b0010; e0 = n + 1;
    go(16); check("A_halt_pre", halt_req, 0);
    go(17); check("A_halt_rise", halt_req, 1); check("A_act_pre", active_mode, 4'b0001);
    go(18); check("A_act", active_mode, 4'b0010);
    go(21); check("A_halt_hold", halt_req, 1); check("A_done_pre", switch_done, 0);
    go(22); check("A_done", switch_done, 1); check("A_halt_fall", halt_req, 0);
    go(23); check("A_done_once", switch_done, 0); check("A_idle", switch_pending, 0);
    // Back to 0001 with a one-cycle bus burst at cycle 10
    d0 = dones; mode_req = 4'b0001; e0 = n + 1;
    go(9); comm_active = 1'b1;
    go(10); comm_active = 1'b0;
    go(27); check("B_act_pre", active_mode, 4'b0010);
    go(28); check("B_act", active_mode, 4'b0001);
    go(33); check("B_one_done", dones - d0, 1);
    // Retarget 0010 -> 0100 while waiting for quiet
    d0 = dones; mode_req = 4'b0010;
    cycles(5); mode_req = 4'b0100;
    cycles(40); check("C_act", active_mode, 4'b0100); check("C_one_done", dones - d0, 1);
    // Request 1000 then back to the active mode: cancel without a pulse
    d0 = dones; mode_req = 4'b1000;
    cycles(5); check("D_pending", switch_pending, 1);
    mode_req = 4'b0100;
    cycles(2); check("D_cancel", switch_pending, 0);
    cycles(30); check("D_no_done", dones - d0, 0); check("D_act", active_mode, 4'b0100);
    // Invalid requests are ignored
    mode_req = 4'b0000;
    cycles(20); check("E_zero", switch_pending, 0);
    mode_req = 4'b0110;
    cycles(20); check("E_multi", switch_pending, 0); check("E_act", active_mode, 4'b0100);
    // Handlers never acknowledge
    halt_ack = 1'b0; mode_req = 4'b0001;
    cycles(5000);
`ifdef MODE_SWITCH_TIMEOUT_EN
    check("F_forced_act", active_mode, 4'b0001); check("F_forced_once", forced_seen, 1);
`else
    check("F_hold_halt", halt_req, 1); check("F_hold_act", active_mode, 4'b0100);
    check("F_no_force", forced_seen, 0);
`endif
    // Asynchronous reset while halted
    mode_req = 4'b0010;
    cycles(20); check("G_in_halt", halt_req, 1);
    #2 rst = 1'b1;
    #1;
    check("G_rst_act", active_mode, 4'b0001);
    check("G_rst_halt", halt_req, 0);
    check("G_rst_pending", switch_pending, 0);
    check("G_rst_done", switch_done, 0);
    cycles(2);
    rst = 1'b0;
    cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
